// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths and address constants for the router datapath
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W     = 2;

    // Address field value that does not select any of the three output ports.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - running XOR parity, packet parity capture and mismatch flag
//   clk, rst        : clock, synchronous active-high reset
//   clr             : start of packet; clears int_par and parity_done
//   xor_en/xor_byte : fold xor_byte into int_par
//   cap_en/cap_byte : capture the packet parity byte into pkt_par
//   chk             : compare int_par against pkt_par (CHECK_PARITY_ERROR)
//   err_clr         : clear err at the start of the next packet
//   int_par, pkt_par, parity_done, err : registered results
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              xor_en,
    input  logic [DATA_W-1:0] xor_byte,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_byte,
    input  logic              chk,
    input  logic              err_clr,
    output logic [DATA_W-1:0] int_par,
    output logic [DATA_W-1:0] pkt_par,
    output logic              parity_done,
    output logic              err
);

    always_ff @(posedge clk) begin
        if (rst) begin
            int_par <= '0;
        end else if (clr) begin
            int_par <= '0;
        end else if (xor_en) begin
            int_par <= int_par ^ xor_byte;
        end
    end

    // Capture wins over clear; the FSM never asserts both in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_par     <= '0;
            parity_done <= 1'b0;
        end else if (cap_en) begin
            pkt_par     <= cap_byte;
            parity_done <= 1'b1;
        end else if (clr) begin
            parity_done <= 1'b0;
        end
    end

    // Only compare once the parity byte has really been captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (chk && parity_done) begin
            err <= (int_par != pkt_par);
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath register stage between input port and output FIFOs
//   clk, rst     : clock, synchronous active-high reset
//   pkt_vld      : source byte valid, drops with the parity byte
//   data_in      : source byte
//   fifo_full    : selected output FIFO is full
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg : FSM state decodes
//   parity_done  : packet parity byte captured
//   low_pkt_vld  : pkt_vld seen low while in LOAD_DATA
//   err          : parity mismatch for the last packet
//   dout         : FIFO write data
//   err_cnt      : saturating count of err rising edges (only with ROUTER_REG_ERR_CNT_EN)
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_vld,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_pkt_vld,
    output logic              err,
    output logic [DATA_W-1:0] dout
`ifdef ROUTER_REG_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] full_byte;
    logic [DATA_W-1:0] int_par;
    logic [DATA_W-1:0] pkt_par;

    logic              xor_en;
    logic [DATA_W-1:0] xor_byte;
    logic              cap_en;
    logic [DATA_W-1:0] cap_byte;

    // Header is only latched for a routable address.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr <= '0;
        end else if (detect_add && pkt_vld && (data_in[ADDR_W-1:0] != ADDR_INVALID)) begin
            hdr <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (lfd_state) begin
            dout <= hdr;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    // Parks the byte that arrived while the FIFO was full; it is replayed in
    // LOAD_AFTER_FULL and stays put throughout FIFO_FULL_STATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_byte <= '0;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_pkt_vld <= 1'b0;
        end else if (ld_state && !pkt_vld) begin
            low_pkt_vld <= 1'b1;
        end else if (rst_int_reg) begin
            low_pkt_vld <= 1'b0;
        end
    end

    // Payload bytes are folded in on arrival, so a byte parked in full_byte is
    // not counted again when it is replayed from LOAD_AFTER_FULL.
    always_comb begin
        xor_en   = 1'b0;
        xor_byte = data_in;
        cap_en   = 1'b0;
        cap_byte = data_in;
        if (lfd_state) begin
            xor_en   = 1'b1;
            xor_byte = hdr;
        end else if (ld_state && pkt_vld) begin
            xor_en   = 1'b1;
        end
        if (ld_state && !pkt_vld && !fifo_full) begin
            cap_en   = 1'b1;
        end else if (laf_state && low_pkt_vld && !parity_done) begin
            // Parity byte arrived while the FIFO was full; finish the capture now.
            cap_en   = 1'b1;
            cap_byte = full_byte;
        end
    end

    router_parity_acc #(
        .DATA_W (DATA_W)
    ) u_par (
        .clk         (clk),
        .rst         (rst),
        .clr         (detect_add),
        .xor_en      (xor_en),
        .xor_byte    (xor_byte),
        .cap_en      (cap_en),
        .cap_byte    (cap_byte),
        .chk         (rst_int_reg),
        .err_clr     (detect_add && pkt_vld),
        .int_par     (int_par),
        .pkt_par     (pkt_par),
        .parity_done (parity_done),
        .err         (err)
    );

`ifdef ROUTER_REG_ERR_CNT_EN
    logic err_q;

    // Counts the cycle after err rises, using the registered previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            err_q <= err;
            if (err && !err_q && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - directed self-checking bench for router_reg
module tb_router_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_vld;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       parity_done;
    logic       low_pkt_vld;
    logic       err;
    logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    router_reg #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_vld     (pkt_vld),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .laf_state   (laf_state),
        .full_state  (full_state),
        .rst_int_reg (rst_int_reg),
        .parity_done (parity_done),
        .low_pkt_vld (low_pkt_vld),
        .err         (err),
        .dout        (dout)
`ifdef ROUTER_REG_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic da, input logic lf, input logic l, input logic la,
                         input logic fs, input logic ri, input logic pv, input logic ff,
                         input logic [7:0] d);
        detect_add  = da;
        lfd_state   = lf;
        ld_state    = l;
        laf_state   = la;
        full_state  = fs;
        rst_int_reg = ri;
        pkt_vld     = pv;
        fifo_full   = ff;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    // One-payload packet through DECODE, LFD, LD, LD(parity), CHECK_PARITY.
    task automatic run_pkt(input logic [7:0] h, input logic [7:0] p, input logic [7:0] par);
        drive(1, 0, 0, 0, 0, 0, 1, 0, h);
        drive(0, 1, 0, 0, 0, 0, 1, 0, p);
        drive(0, 0, 1, 0, 0, 0, 1, 0, p);
        drive(0, 0, 1, 0, 0, 0, 0, 0, par);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b0;
        nvec++; if (dout !== 8'h00) begin nerr++; $display("FAIL rst_dout got %h exp 00", dout); end
        nvec++; if (parity_done !== 1'b0 || low_pkt_vld !== 1'b0 || err !== 1'b0) begin
            nerr++; $display("FAIL rst_flags got pd=%b lpv=%b err=%b exp 000", parity_done, low_pkt_vld, err);
        end
        nvec++; if (dut.hdr !== 8'h00 || dut.u_par.int_par !== 8'h00) begin
            nerr++; $display("FAIL rst_regs got hdr=%h int_par=%h exp 00 00", dut.hdr, dut.u_par.int_par);
        end
    endtask

    task automatic test_nominal();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
        nvec++; if (dut.hdr !== 8'h05) begin nerr++; $display("FAIL nom_hdr got %h exp 05", dut.hdr); end
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA3);
        nvec++; if (dout !== 8'h05) begin nerr++; $display("FAIL nom_dout_hdr got %h exp 05", dout); end
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'hA3);
        nvec++; if (dout !== 8'hA3) begin nerr++; $display("FAIL nom_dout_pay got %h exp A3", dout); end
        nvec++; if (dut.u_par.int_par !== 8'hA6) begin nerr++; $display("FAIL nom_int_par got %h exp A6", dut.u_par.int_par); end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'hA6);
        nvec++; if (dout !== 8'hA6 || parity_done !== 1'b1 || low_pkt_vld !== 1'b1) begin
            nerr++; $display("FAIL nom_par got dout=%h pd=%b lpv=%b exp A6 1 1", dout, parity_done, low_pkt_vld);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        nvec++; if (err !== 1'b0 || low_pkt_vld !== 1'b0) begin
            nerr++; $display("FAIL nom_chk got err=%b lpv=%b exp 0 0", err, low_pkt_vld);
        end
    endtask

    task automatic test_bad_parity();
        run_pkt(8'h05, 8'hA3, 8'h00);
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL bad_err got %b exp 1", err); end
        nvec++; if (dut.u_par.pkt_par !== 8'h00) begin nerr++; $display("FAIL bad_pkt_par got %h exp 00", dut.u_par.pkt_par); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL bad_err_hold got %b exp 1", err); end
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h06);
        nvec++; if (err !== 1'b0 || parity_done !== 1'b0) begin
            nerr++; $display("FAIL bad_err_clr got err=%b pd=%b exp 0 0", err, parity_done);
        end
    endtask

    task automatic test_full_payload();
        // header 09, payload 11 3C, parity 09^11^3C = 24
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h09);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
        drive(0, 0, 1, 0, 0, 0, 1, 1, 8'h3C);
        nvec++; if (dout !== 8'h11 || dut.full_byte !== 8'h3C) begin
            nerr++; $display("FAIL fp_park got dout=%h full_byte=%h exp 11 3C", dout, dut.full_byte);
        end
        drive(0, 0, 0, 0, 1, 0, 1, 1, 8'h55);
        nvec++; if (dout !== 8'h11 || dut.full_byte !== 8'h3C) begin
            nerr++; $display("FAIL fp_hold got dout=%h full_byte=%h exp 11 3C", dout, dut.full_byte);
        end
        drive(0, 0, 0, 1, 0, 0, 1, 0, 8'h55);
        nvec++; if (dout !== 8'h3C || dut.u_par.int_par !== 8'h24 || parity_done !== 1'b0) begin
            nerr++; $display("FAIL fp_laf got dout=%h int_par=%h pd=%b exp 3C 24 0", dout, dut.u_par.int_par, parity_done);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'h24);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        nvec++; if (err !== 1'b0 || dut.u_par.pkt_par !== 8'h24) begin
            nerr++; $display("FAIL fp_chk got err=%b pkt_par=%h exp 0 24", err, dut.u_par.pkt_par);
        end
    endtask

    task automatic test_full_on_parity();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA3);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'hA3);
        drive(0, 0, 1, 0, 0, 0, 0, 1, 8'hA6);
        nvec++; if (low_pkt_vld !== 1'b1 || parity_done !== 1'b0 || dout !== 8'hA3 || dut.full_byte !== 8'hA6) begin
            nerr++; $display("FAIL fop_park got lpv=%b pd=%b dout=%h fb=%h exp 1 0 A3 A6",
                             low_pkt_vld, parity_done, dout, dut.full_byte);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
        nvec++; if (parity_done !== 1'b0) begin nerr++; $display("FAIL fop_fs_pd got %b exp 0", parity_done); end
        drive(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        nvec++; if (parity_done !== 1'b1 || dut.u_par.pkt_par !== 8'hA6 || dout !== 8'hA6) begin
            nerr++; $display("FAIL fop_laf got pd=%b pkt_par=%h dout=%h exp 1 A6 A6", parity_done, dut.u_par.pkt_par, dout);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL fop_err got %b exp 0", err); end
    endtask

    task automatic test_invalid_addr();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h07);
        nvec++; if (dut.hdr !== 8'h05) begin nerr++; $display("FAIL inv_hdr got %h exp 05", dut.hdr); end
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h0A);
        nvec++; if (dut.hdr !== 8'h0A) begin nerr++; $display("FAIL inv_hdr_ok got %h exp 0A", dut.hdr); end
    endtask

    task automatic test_reset_mid_packet();
        run_pkt(8'h05, 8'hA3, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA3);
        drive(0, 0, 1, 0, 0, 0, 1, 1, 8'hA3);
        rst = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'hA6);
        rst = 1'b0;
        nvec++; if (dout !== 8'h00 || parity_done !== 1'b0 || low_pkt_vld !== 1'b0 || err !== 1'b0) begin
            nerr++; $display("FAIL rmp_out got dout=%h pd=%b lpv=%b err=%b exp 00 0 0 0",
                             dout, parity_done, low_pkt_vld, err);
        end
        nvec++; if (dut.u_par.int_par !== 8'h00 || dut.hdr !== 8'h00 || dut.full_byte !== 8'h00 || dut.u_par.pkt_par !== 8'h00) begin
            nerr++; $display("FAIL rmp_regs got int=%h hdr=%h fb=%h pp=%h exp 00",
                             dut.u_par.int_par, dut.hdr, dut.full_byte, dut.u_par.pkt_par);
        end
        run_pkt(8'h05, 8'hA3, 8'hA6);
        nvec++; if (err !== 1'b0 || parity_done !== 1'b1) begin
            nerr++; $display("FAIL rmp_next got err=%b pd=%b exp 0 1", err, parity_done);
        end
    endtask

`ifdef ROUTER_REG_ERR_CNT_EN
    task automatic test_err_cnt();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b0;
        nvec++; if (err_cnt !== 8'h00) begin nerr++; $display("FAIL cnt_rst got %h exp 00", err_cnt); end
        for (int i = 0; i < 3; i++) run_pkt(8'h05, 8'hA3, 8'h00);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        nvec++; if (err_cnt !== 8'h03) begin nerr++; $display("FAIL cnt_three got %h exp 03", err_cnt); end
        for (int i = 3; i < 256; i++) run_pkt(8'h05, 8'hA3, 8'h00);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        nvec++; if (err_cnt !== 8'hFF) begin nerr++; $display("FAIL cnt_sat got %h exp FF", err_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        pkt_vld = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
        laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
        #2;
        test_reset();
        test_nominal();
        test_bad_parity();
        test_full_payload();
        test_full_on_parity();
        test_invalid_addr();
        test_reset_mid_packet();
`ifdef ROUTER_REG_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router.
- Sits between the input port and the three output FIFOs, driven by the router FSM's state decodes.
- Latches the header, forwards payload bytes to the FIFO write bus, and parks the byte that arrives while the FIFO is full.
- Accumulates running XOR parity, compares it against the packet's parity byte, and returns parity_done / low_pkt_vld to the FSM.

Parameters:
- DATA_W, 8, byte width of data_in/dout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pkt_vld  input  1  source byte valid; deasserts with the parity byte
- data_in  input  DATA_W  source byte
- fifo_full  input  1  selected output FIFO full
- detect_add  input  1  FSM in DECODE_ADDRESS
- lfd_state  input  1  FSM in LOAD_FIRST_DATA
- ld_state  input  1  FSM in LOAD_DATA
- laf_state  input  1  FSM in LOAD_AFTER_FULL
- full_state  input  1  FSM in FIFO_FULL_STATE
- rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR
- parity_done  output  1  packet parity byte captured
- low_pkt_vld  output  1  pkt_vld seen low inside LOAD_DATA
- err  output  1  parity mismatch for the last packet
- dout  output  DATA_W  FIFO write data

Behaviour:
- Reset (rst=1 at a clk edge): all outputs and internal registers go to 0. These are hdr, full_byte, int_par and pkt_par.
- All updates occur on the clk rising edge. No combinational paths from inputs to outputs.
- hdr:
  - Loads data_in when detect_add && pkt_vld && data_in[1:0]!=2'b11.
  - Otherwise holds.
- dout, by priority:
  1. lfd_state -> hdr.
  2. ld_state && !fifo_full -> data_in.
  3. ld_state && fifo_full -> hold.
  4. laf_state -> full_byte.
  5. Otherwise hold.
- full_byte:
  - Loads data_in when ld_state && fifo_full.
  - Holds while full_state.
- int_par:
  - Cleared on detect_add.
  - lfd_state: int_par ^= hdr.
  - ld_state && pkt_vld: int_par ^= data_in. Each payload byte is counted exactly once, whether it goes to dout or to full_byte.
  - Otherwise holds.
- pkt_par and parity_done:
  - pkt_par loads data_in when ld_state && !pkt_vld && !fifo_full. In the same cycle parity_done is set to 1.
  - pkt_par also loads when laf_state && low_pkt_vld && !parity_done. In that case it loads from full_byte, and parity_done is set to 1.
  - parity_done is cleared on detect_add.
  - Set has priority over clear; the two cannot coincide legally.
- low_pkt_vld:
  - Set when ld_state && !pkt_vld.
  - Cleared when rst_int_reg.
- err:
  - When rst_int_reg && parity_done, err <= (int_par != pkt_par).
  - Cleared on detect_add && pkt_vld, i.e. the start of the next packet.
  - Otherwise holds. Valid from the cycle after CHECK_PARITY_ERROR.
- Simultaneous events:
  - fifo_full rising in the same cycle as the parity byte: the byte goes to full_byte and parity_done stays 0. LOAD_AFTER_FULL then completes the capture.
- Reset mid-packet: all state clears in one cycle. No stale header or parity leaks into the next packet.

Optional Feature:
- Macro ROUTER_REG_ERR_CNT_EN.
- When defined, adds output err_cnt (8 bits).
  - Increments by 1 in each cycle in which err transitions 0->1.
  - Saturates at 8'hFF.
  - Cleared only by rst.
- When undefined, the port and its counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W default;
  - ADDR_INVALID = 2'b11;
  - ADDR_W = 2.
- One natural sub-module, router_parity_acc. It contains int_par, pkt_par, parity_done and the err compare. Inputs are the clear, XOR-enable, capture-enable and byte signals.
- The top level keeps the hdr/dout/full_byte muxing.

Test Plan:
- Nominal packet, good parity:
  - Stimulus: header 8'h05 (len 1, addr 1), payload 8'hA3, parity 8'hA6.
  - Response: dout sequence 05, A3, A6; parity_done=1; err=0 after CHECK_PARITY_ERROR.
- Bad parity:
  - Stimulus: same packet with parity byte 8'h00.
  - Response: err=1 one cycle after rst_int_reg. err clears on the next header with pkt_vld.
- FIFO full mid-payload:
  - Stimulus: fifo_full=1 while 8'h3C arrives in ld_state.
  - Response: dout holds the prior byte; full_byte=8'h3C; dout=8'h3C in laf_state. int_par includes 3C once.
- Full on the parity byte:
  - Stimulus: pkt_vld=0 and fifo_full=1 together.
  - Response: low_pkt_vld=1, parity_done=0. In laf_state, parity_done=1 and pkt_par=full_byte.
- Invalid address:
  - Stimulus: detect_add with data_in=8'h07 (addr 2'b11).
  - Response: hdr unchanged.
- Reset mid-packet:
  - Stimulus: rst=1 during ld_state.
  - Response: next cycle dout=0, parity_done=0, low_pkt_vld=0, err=0, int_par=0.
  - With ROUTER_REG_ERR_CNT_EN: err_cnt=0 after reset; 256 bad packets leave err_cnt=8'hFF.
